// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the single write port of a fifo_controller-based FIFO between N_REQ
// producers. A requester wins the port in IDLE (one cycle of arbitration
// latency) and then owns it non-preemptively for a burst. The burst ends on
// the owner's last word, on MAX_BURST words, or when the owner drops req.
// Round-robin order restarts after the owner of the burst that just ended.
// The FIFO full flag stalls the burst without ending it.
//
// Optional feature macro: FIFO_ARB_PRIO_EN
//   defined   : requester 0 wins every IDLE arbitration it takes part in.
//               The other requesters are scanned round-robin from rr_ptr.
//               rr_ptr is left untouched when a burst of requester 0 ends.
//   undefined : pure round-robin, all requesters equal.
//
// Parameters
//   N_REQ       number of producers, 2..8
//   DATA_WIDTH  write data width
//   MAX_BURST   max words per grant, 1..15
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   req          in   [N_REQ]            producer i has a word on its data slice
//   data         in   [N_REQ*DATA_WIDTH] producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   last         in   [N_REQ]            current word of producer i ends its burst
//   gnt          out  [N_REQ]            one-hot; word of producer i accepted this cycle
//   fifo_full    in   FIFO full flag
//   fifo_w_en    out  FIFO write enable
//   fifo_w_data  out  [DATA_WIDTH]       FIFO write data (0 when nothing is granted)
//   busy         out  a burst owner is held
//   owner        out  [3]                index of current/last owner
// ----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] data,
    input  logic [N_REQ-1:0]            last,
    output logic [N_REQ-1:0]            gnt,
    input  logic                        fifo_full,
    output logic                        fifo_w_en,
    output logic [DATA_WIDTH-1:0]       fifo_w_data,
    output logic                        busy,
    output logic [2:0]                  owner
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Constants sized to the counters they are compared against.
    localparam logic [3:0] N_REQ_W   = 4'(N_REQ);
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t     state_q,    state_d;
    logic [2:0] owner_q,    owner_d;
    logic [2:0] rr_ptr_q,   rr_ptr_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;

    // ------------------------------------------------------------------
    // Helper signals
    // ------------------------------------------------------------------
    // req/last padded to 8 bits so a 3-bit index always fits exactly,
    // whatever N_REQ is.
    logic [7:0]            req_pad;
    logic [7:0]            last_pad;
    logic                  owner_req;
    logic                  owner_last;
    logic                  transfer;
    logic                  burst_end;
    logic                  any_req;
    logic [2:0]            rr_pick;
    logic [2:0]            arb_pick;
    logic [3:0]            owner_sum;
    logic [2:0]            owner_inc;
    logic [2:0]            rr_next;
    logic [N_REQ-1:0]      owner_sel;
    logic [DATA_WIDTH-1:0] word_masked [N_REQ];

    assign req_pad  = 8'(req);
    assign last_pad = 8'(last);
    assign any_req  = |req;

    assign owner_req  = req_pad[owner_q];
    assign owner_last = last_pad[owner_q];

    // A word moves only while a burst is held, the owner offers one and the
    // FIFO has room. Non-owner requests never reach this term.
    assign transfer = (state_q == ST_BURST) & owner_req & ~fifo_full;

    // Burst ends on the owner's last word, on the MAX_BURST-th word, or
    // when the owner withdraws its request (no word moves that cycle).
    assign burst_end = (transfer & (owner_last | (beat_cnt_q == LAST_BEAT)))
                     | ~owner_req;

    // owner + 1 wrapped explicitly at N_REQ rather than by bit overflow.
    assign owner_sum = {1'b0, owner_q} + 4'd1;
    assign owner_inc = (owner_sum == N_REQ_W) ? 3'd0 : owner_sum[2:0];

    // One-hot decode of the owner, used for gnt and the data mux.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_owner_sel
            assign owner_sel[gi] = (owner_q == 3'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin scan: first requester at rr_ptr, rr_ptr+1, ... mod N_REQ.
    // rr_ptr is always below N_REQ, so one conditional subtract wraps.
    // ------------------------------------------------------------------
    always_comb begin
        logic [3:0] cand;
        logic       found;
        rr_pick = 3'd0;
        found   = 1'b0;
        cand    = 4'd0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + 4'(k);
            if (cand >= N_REQ_W) begin
                cand = cand - N_REQ_W;
            end
            if (!found && req_pad[cand[2:0]]) begin
                rr_pick = cand[2:0];
                found   = 1'b1;
            end
        end
    end

`ifdef FIFO_ARB_PRIO_EN
    // Requester 0 jumps the round-robin queue; the pointer is not advanced
    // past it so the rotation among the others is undisturbed.
    assign arb_pick = req[0] ? 3'd0 : rr_pick;
    assign rr_next  = (owner_q == 3'd0) ? rr_ptr_q : owner_inc;
`else
    assign arb_pick = rr_pick;
    assign rr_next  = owner_inc;
`endif

    // ------------------------------------------------------------------
    // FSM process 1: state register (asynchronous reset)
    // A reset mid-burst simply drops the word in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= 3'd0;
            rr_ptr_q   <= 3'd0;
            beat_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // IDLE never writes: it only latches the winner, so there is always at
    // least one idle cycle between two bursts. fifo_full does not hold off
    // arbitration; it only stalls the burst that follows.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d    = ST_BURST;
                    owner_d    = arb_pick;
                    beat_cnt_d = 4'd0;
                end
            end
            ST_BURST: begin
                if (transfer) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
                if (burst_end) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = rr_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q == ST_BURST);
        owner     = owner_q;
        fifo_w_en = transfer;
        gnt       = owner_sel & {N_REQ{transfer}};
    end

    // Write data: AND-OR mux keyed on gnt, so it reads 0 whenever nothing
    // is granted (including during reset).
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_word_mask
            assign word_masked[gi] = data[gi*DATA_WIDTH +: DATA_WIDTH]
                                   & {DATA_WIDTH{gnt[gi]}};
        end
    endgenerate

    always_comb begin
        fifo_w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            fifo_w_data = fifo_w_data | word_masked[i];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter (N_REQ=4, DATA_WIDTH=8,
// MAX_BURST=4). A behavioural model tracks "who owns the port, how many
// words it has moved, where the round-robin restarts" and predicts every
// output each cycle; directed scenarios add hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic [N-1:0]    last;
    logic [N-1:0]    gnt;
    logic            fifo_full;
    logic            fifo_w_en;
    logic [DW-1:0]   fifo_w_data;
    logic            busy;
    logic [2:0]      owner;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    bit m_busy;
    int m_owner;
    int m_words;
    int m_rr;

    fifo_wr_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .data        (data),
        .last        (last),
        .gnt         (gnt),
        .fifo_full   (fifo_full),
        .fifo_w_en   (fifo_w_en),
        .fifo_w_data (fifo_w_data),
        .busy        (busy),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_words = 0;
        m_rr    = 0;
    endtask

    // Winner of an IDLE arbitration, -1 if nobody asks.
    function automatic int m_pick(input logic [N-1:0] r);
`ifdef FIFO_ARB_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (r[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // Compare every output against the model for the current cycle.
    task automatic sample();
        bit            xfer;
        logic [N-1:0]  eg;
        logic [DW-1:0] ed;
        #1;
        xfer = m_busy && req[m_owner] && !fifo_full && !reset;
        eg   = '0;
        ed   = '0;
        if (xfer) begin
            eg[m_owner] = 1'b1;
            ed          = data[m_owner*DW +: DW];
        end
        check("gnt",         32'(gnt),         32'(eg));
        check("fifo_w_en",   32'(fifo_w_en),   32'(xfer));
        check("fifo_w_data", 32'(fifo_w_data), 32'(ed));
        check("busy",        32'(busy),        32'(m_busy));
        check("owner",       32'(owner),       32'(m_owner));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("wen_vs_full", 32'(fifo_w_en & fifo_full), 32'd0);
        if (xfer) begin
            $display("[TB] t=%0t write owner=%0d data=%02h words=%0d", $time, m_owner, ed, m_words + 1);
        end
    endtask

    // Clock edge: advance the model with the inputs of the cycle just sampled.
    task automatic advance();
        int p;
        bit xfer;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (!m_busy) begin
            p = m_pick(req);
            if (p >= 0) begin
                m_busy  = 1'b1;
                m_owner = p;
                m_words = 0;
            end
        end else begin
            xfer = req[m_owner] && !fifo_full;
            if (xfer) m_words++;
            if ((xfer && (last[m_owner] || m_words == MB)) || !req[m_owner]) begin
                m_busy = 1'b0;
`ifdef FIFO_ARB_PRIO_EN
                if (m_owner != 0) m_rr = (m_owner + 1) % N;
`else
                m_rr = (m_owner + 1) % N;
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic f);
        req       = r;
        last      = l;
        fifo_full = f;
        data      = {$urandom, $urandom};
        sample();
    endtask

    // One reset cycle; inputs keep whatever the caller left on them.
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        sample();
        advance();
        reset = 1'b0;
    endtask

    function automatic int gnt_index(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    logic [N-1:0] t3_gnt  [9] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                                  4'b0000, 4'b0100, 4'b0100, 4'b0000};
    logic         t3_full [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    logic         t3_busy [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        reset     = 1'b1;
        req       = '0;
        last      = '0;
        fifo_full = 1'b0;
        data      = '0;
        model_reset();
        @(negedge clk);

        // ---- 1: single word burst from requester 0 ----
        do_reset();
        check("t1_rst_busy", 32'(busy), 32'd0);
        cyc(4'b0001, 4'b0001, 1'b0);
        check("t1_arb_gnt", 32'(gnt), 32'd0);
        advance();
        cyc(4'b0001, 4'b0001, 1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_gnt",  32'(gnt),  32'b0001);
        check("t1_wen",  32'(fifo_w_en), 32'd1);
        advance();
        cyc(4'b0000, 4'b0000, 1'b0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_model_rr", 32'(m_rr), 32'd1);
        advance();

        // ---- 2: all request, no last: 4 words each, owners 0,1,2,3,0 ----
        cyc(4'b0000, 4'b0000, 1'b0);
        do_reset();
        for (int c = 0; c < 25; c++) begin
            cyc(4'b1111, 4'b0000, 1'b0);
            check($sformatf("t2_owner_c%0d", c), 32'(gnt_index(gnt)),
                  32'((c % 5 == 0) ? -1 : (c / 5) % 4));
            advance();
        end

        // ---- 3: owner 2 stalled by fifo_full for 3 cycles ----
        cyc(4'b0000, 4'b0000, 1'b0);
        do_reset();
        for (int c = 0; c < 9; c++) begin
            cyc(4'b0100, 4'b0000, t3_full[c]);
            check($sformatf("t3_gnt_c%0d", c),  32'(gnt),  32'(t3_gnt[c]));
            check($sformatf("t3_busy_c%0d", c), 32'(busy), 32'(t3_busy[c]));
            advance();
        end

        // ---- 4: owner 1 abandons after 2 words ----
        cyc(4'b0000, 4'b0000, 1'b0);
        do_reset();
        cyc(4'b0010, 4'b0000, 1'b0); advance();
        cyc(4'b0010, 4'b0000, 1'b0); advance();
        cyc(4'b0010, 4'b0000, 1'b0); advance();
        cyc(4'b0000, 4'b0000, 1'b0);
        check("t4_drop_wen",  32'(fifo_w_en), 32'd0);
        check("t4_drop_busy", 32'(busy), 32'd1);
        advance();
        cyc(4'b1111, 4'b0000, 1'b0);
        check("t4_idle", 32'(busy), 32'd0);
        advance();
        cyc(4'b1111, 4'b0000, 1'b0);
        check("t4_next_owner", 32'(owner), 32'd2);
        check("t4_next_gnt",   32'(gnt),   32'b0100);
        advance();

        // ---- 5: reset mid-burst, restart from requester 0 ----
        cyc(4'b0000, 4'b0000, 1'b0);
        do_reset();
        cyc(4'b0010, 4'b0000, 1'b0); advance();
        cyc(4'b0010, 4'b0000, 1'b0); advance();
        cyc(4'b0010, 4'b0000, 1'b0); advance();
        req   = 4'b1111;
        reset = 1'b1;
        model_reset();
        sample();
        check("t5_rst_gnt",   32'(gnt),         32'd0);
        check("t5_rst_wen",   32'(fifo_w_en),   32'd0);
        check("t5_rst_data",  32'(fifo_w_data), 32'd0);
        check("t5_rst_busy",  32'(busy),        32'd0);
        check("t5_rst_owner", 32'(owner),       32'd0);
        advance();
        reset = 1'b0;
        cyc(4'b1111, 4'b0000, 1'b0); advance();
        cyc(4'b1111, 4'b0000, 1'b0);
        check("t5_restart_owner", 32'(owner), 32'd0);
        check("t5_restart_gnt",   32'(gnt),   32'b0001);
        advance();

`ifdef FIFO_ARB_PRIO_EN
        // ---- 6: requester 0 overtakes 3 once owner 2 finishes ----
        cyc(4'b0000, 4'b0000, 1'b0);
        do_reset();
        for (int c = 0; c < 12; c++) begin
            cyc((c >= 7) ? 4'b1111 : 4'b1110, 4'b0000, 1'b0);
            if (c == 6) check("t6_owner2", 32'(owner), 32'd2);
            if (c == 11) begin
                check("t6_prio_owner", 32'(owner), 32'd0);
                check("t6_prio_gnt",   32'(gnt),   32'b0001);
            end
            advance();
        end
`endif

        // ---- random traffic against the model ----
        cyc(4'b0000, 4'b0000, 1'b0);
        do_reset();
        begin
            logic [N-1:0] r;
            logic [N-1:0] l;
            r = '0;
            for (int c = 0; c < 2500; c++) begin
                for (int i = 0; i < N; i++) begin
                    if (r[i]) r[i] = ($urandom_range(15) != 0);
                    else      r[i] = ($urandom_range(3) == 0);
                    l[i] = ($urandom_range(4) == 0);
                end
                if ($urandom_range(299) == 0) begin
                    req  = r;
                    last = l;
                    do_reset();
                end else begin
                    cyc(r, l, $urandom_range(4) == 0);
                    advance();
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
